// File: rtl/trig_lut_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trig_lut_sequencer_pkg
// Shared definitions for the trig LUT sequencer and its round-robin arbiter:
//   - FSM state encoding of the sequencer
//   - angle reduction constants (90/180/270/360 degrees)
//   - function select encoding (SIN=0, COS=1)
//   - DATA_WIDTH, the table index width: 7 bits (enough for 0..90)
// -----------------------------------------------------------------------------
package trig_lut_sequencer_pkg;

    localparam int DATA_WIDTH = 7;

    localparam logic [8:0] ANG_90  = 9'd90;
    localparam logic [8:0] ANG_180 = 9'd180;
    localparam logic [8:0] ANG_270 = 9'd270;
    localparam logic [8:0] ANG_360 = 9'd360;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REDUCE  = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic {
        FUNC_SIN = 1'b0,
        FUNC_COS = 1'b1
    } func_t;

endpackage

// File: rtl/trig_lut_sequencer_arbiter.sv
// -----------------------------------------------------------------------------
// trig_rr_arbiter
// NUM_REQ-wide round-robin arbiter. The search for a winner starts at the
// priority pointer; on every grant the pointer moves to the requester just
// after the winner. The pointer resets to requester 0.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   enable      - grants are only issued while high
//   req         - request vector
//   grant       - one-hot grant (zero when nothing is granted)
//   grant_id    - binary index of the granted requester
//   grant_any   - a grant is issued this cycle (accept)
// -----------------------------------------------------------------------------
module trig_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] ptr;
    int              idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (enable && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/trig_lut_sequencer.sv
// -----------------------------------------------------------------------------
// trig_lut_sequencer
// Front-end controller for the sine/cosine double-precision lookup tables.
// Arbitrates between NUM_REQ requesters, reduces the angle to a quadrant and
// a 0..90 index, pulses the selected table enable for one cycle, captures the
// table result one cycle later and returns it on a tagged valid/ready channel.
// Configuration macro: TRIG_ANGLE_WRAP_EN - when defined, angles 360..511 are
// wrapped by subtracting 360; when undefined they return resp_err=1.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (ready only in IDLE)
//   req_angle             - 9-bit angle per requester, packed
//   req_func              - per-requester function, 0=sin 1=cos
//   resp_valid/resp_ready - response handshake
//   resp_id, resp_data    - owner tag and IEEE-754 double result
//   resp_err              - angle out of range
//   lut_en_sin/lut_en_cos - table enables (one-cycle pulse)
//   lut_quadrant          - quadrant 0..3 to the tables
//   lut_index             - reduced angle 0..90 to the tables
//   lut_sin_data/cos_data - table outputs
// -----------------------------------------------------------------------------
module trig_lut_sequencer
    import trig_lut_sequencer_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*9-1:0]  req_angle,
    input  logic [NUM_REQ-1:0]    req_func,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [63:0]           resp_data,
    output logic                  resp_err,
    output logic                  lut_en_sin,
    output logic                  lut_en_cos,
    output logic [1:0]            lut_quadrant,
    output logic [DATA_WIDTH-1:0] lut_index,
    input  logic [63:0]           lut_sin_data,
    input  logic [63:0]           lut_cos_data
);

    state_t                state, state_nx;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  grant_any;
    logic                  arb_en;
    logic [8:0]            sel_angle;
    logic                  sel_func;

    logic [8:0]            angle_r;
    func_t                 func_r;
    logic [ID_W-1:0]       id_r;
    logic [1:0]            q_r;
    logic [DATA_WIDTH-1:0] r_r;
    logic                  err_r;
    logic [63:0]           data_r;

    logic [8:0]            angle_n;
    logic                  range_err;
    logic [1:0]            q_n;
    logic [DATA_WIDTH-1:0] r_n;

    // A table result of +/-0.0 is always returned as +0.0.
    function automatic logic [63:0] clear_neg_zero(input logic [63:0] d);
        return (d[62:0] == 63'd0) ? 64'd0 : d;
    endfunction

    // Reset is folded in so req_ready is low while reset is asserted.
    assign arb_en    = (state == ST_IDLE) && !reset;
    assign req_ready = grant;

    trig_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .enable    (arb_en),
        .req       (req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_angle = '0;
        sel_func  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_angle = req_angle[i*9 +: 9];
                sel_func  = req_func[i];
            end
        end
    end

    // Quadrant reduction; odd quadrants mirror the index so it runs 90 -> 0.
    always_comb begin
        angle_n   = angle_r;
        range_err = 1'b0;
`ifdef TRIG_ANGLE_WRAP_EN
        if (angle_r >= ANG_360) angle_n = angle_r - ANG_360;
`else
        range_err = (angle_r >= ANG_360);
`endif
        if (angle_n >= ANG_270) begin
            q_n = 2'd3;
            r_n = DATA_WIDTH'(ANG_360 - angle_n);
        end else if (angle_n >= ANG_180) begin
            q_n = 2'd2;
            r_n = DATA_WIDTH'(angle_n - ANG_180);
        end else if (angle_n >= ANG_90) begin
            q_n = 2'd1;
            r_n = DATA_WIDTH'(ANG_180 - angle_n);
        end else begin
            q_n = 2'd0;
            r_n = DATA_WIDTH'(angle_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Operation data; every output it reaches is gated by state, so it
    // needs no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && grant_any) begin
            angle_r <= sel_angle;
            func_r  <= func_t'(sel_func);
            id_r    <= grant_id;
        end
        if (state == ST_REDUCE) begin
            q_r   <= q_n;
            r_r   <= r_n;
            err_r <= range_err;
            if (range_err) data_r <= 64'd0;
        end
        if (state == ST_CAPTURE) begin
            data_r <= clear_neg_zero((func_r == FUNC_COS) ? lut_cos_data : lut_sin_data);
        end
    end

    always_comb begin
        state_nx     = state;
        lut_en_sin   = 1'b0;
        lut_en_cos   = 1'b0;
        lut_quadrant = '0;
        lut_index    = '0;
        resp_valid   = 1'b0;
        resp_id      = '0;
        resp_data    = '0;
        resp_err     = 1'b0;
        case (state)
            ST_IDLE:    if (grant_any) state_nx = ST_REDUCE;
            ST_REDUCE:  state_nx = range_err ? ST_RESP : ST_LOOKUP;
            ST_LOOKUP: begin
                lut_en_sin   = (func_r == FUNC_SIN);
                lut_en_cos   = (func_r == FUNC_COS);
                lut_quadrant = q_r;
                lut_index    = r_r;
                state_nx     = ST_CAPTURE;
            end
            ST_CAPTURE: state_nx = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_id    = id_r;
                resp_data  = data_r;
                resp_err   = err_r;
                if (resp_ready) state_nx = ST_IDLE;
            end
            default:    state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trig_lut_sequencer.sv
module tb_trig_lut_sequencer;
    localparam int  NUM_REQ = 2;
    localparam int  ID_W    = 3;
    localparam int  DW      = trig_lut_sequencer_pkg::DATA_WIDTH;
    localparam real PI      = 3.141592653589793;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*9-1:0] req_angle = '0;
    logic [NUM_REQ-1:0]   req_func = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b1;
    logic [ID_W-1:0]      resp_id;
    logic [63:0]          resp_data;
    logic                 resp_err;
    logic                 lut_en_sin, lut_en_cos;
    logic [1:0]           lut_quadrant;
    logic [DW-1:0]        lut_index;
    logic [63:0]          lut_sin_data, lut_cos_data;

    int          checks = 0;
    int          errors = 0;
    int          rr_next = 0;
    logic [63:0] last_data = '0;

    always #5 clk = ~clk;

    trig_lut_sequencer #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_func(req_func), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .lut_en_sin(lut_en_sin), .lut_en_cos(lut_en_cos),
        .lut_quadrant(lut_quadrant), .lut_index(lut_index),
        .lut_sin_data(lut_sin_data), .lut_cos_data(lut_cos_data)
    );

    // Table value for a quadrant/index pair: magnitude from the first
    // quadrant, sign from the quadrant (exact +/-0 and 1 at the ends).
    function automatic logic [63:0] lut_model(input bit fn, input int q, input int r);
        real         mag;
        logic [63:0] b;
        mag   = fn ? $sin((90 - r) * PI / 180.0) : $sin(r * PI / 180.0);
        b     = $realtobits(mag);
        b[63] = fn ? (q == 1 || q == 2) : (q >= 2);
        return b;
    endfunction

    function automatic logic [63:0] exp_data(input bit fn, input int q, input int r);
        logic [63:0] b;
        b = lut_model(fn, q, r);
        return (b[62:0] == 63'd0) ? 64'd0 : b;
    endfunction

    function automatic void ref_reduce(input int ang, output bit err, output int q, output int r);
        int a;
        a   = ang;
        err = 1'b0;
`ifdef TRIG_ANGLE_WRAP_EN
        if (a >= 360) a = a - 360;
`else
        if (a >= 360) err = 1'b1;
`endif
        q = a / 90;
        r = (q % 2 == 1) ? 90 * (q + 1) - a : a - 90 * q;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int id);
        logic [NUM_REQ-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

    // Registered table emulation: output valid the cycle after the enable,
    // junk otherwise (stands in for the tri-stated bus).
    logic        sin_vld = 1'b0, cos_vld = 1'b0;
    logic [63:0] sin_val = '0, cos_val = '0;
    always @(posedge clk) begin
        sin_vld <= lut_en_sin;
        cos_vld <= lut_en_cos;
        if (lut_en_sin) sin_val <= lut_model(1'b0, int'(lut_quadrant), int'(lut_index));
        if (lut_en_cos) cos_val <= lut_model(1'b1, int'(lut_quadrant), int'(lut_index));
    end
    assign lut_sin_data = sin_vld ? sin_val : 64'hFFF8_DEAD_0000_BEEF;
    assign lut_cos_data = cos_vld ? cos_val : 64'h7FF1_5A5A_C0DE_0001;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_outs"}, {req_ready, resp_valid, resp_err, lut_en_sin, lut_en_cos,
                             lut_quadrant, lut_index, resp_id}, '0);
        chk({tag, "_data"}, resp_data, 64'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_op(input int id, input int ang, input bit fn, input int stall, input bit release_resp);
        bit          err;
        int          q, r;
        logic [63:0] ed;
        ref_reduce(ang, err, q, r);
        resp_ready = (stall == 0);
        req_angle[id*9 +: 9] = 9'(ang);
        req_func[id]  = fn;
        req_valid[id] = 1'b1;
        #1;
        chk("grant", req_ready, onehot(id));
        @(negedge clk);
        req_valid[id] = 1'b0;
        rr_next = (id + 1) % NUM_REQ;
        chk("reduce_quiet", {req_ready, resp_valid, lut_en_sin, lut_en_cos}, '0);
        @(negedge clk);
        if (err) begin
            chk("err_valid", resp_valid, 1);
            chk("err_flag", resp_err, 1);
            chk("err_data", resp_data, 0);
            chk("err_id", resp_id, id);
            chk("err_noen", {lut_en_sin, lut_en_cos}, 0);
            ed = 64'd0;
        end else begin
            chk("lookup_en", {lut_en_sin, lut_en_cos}, fn ? 2'b01 : 2'b10);
            chk("lookup_q", lut_quadrant, q);
            chk("lookup_idx", lut_index, r);
            chk("lookup_novld", resp_valid, 0);
            @(negedge clk);
            chk("capture_noen", {lut_en_sin, lut_en_cos, resp_valid}, 0);
            @(negedge clk);
            ed = exp_data(fn, q, r);
            chk("resp_valid", resp_valid, 1);
            chk("resp_data", resp_data, ed);
            chk("resp_id", resp_id, id);
            chk("resp_err", resp_err, 0);
        end
        last_data = resp_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, ed);
            chk("hold_id", resp_id, id);
            chk("hold_noready", req_ready, 0);
        end
        if (release_resp) begin
            resp_ready = 1'b1;
            @(negedge clk);
            chk("resp_done", resp_valid, 0);
        end
    endtask

    initial begin
        int              c_grants;
        int              exp_ids[$];
        int              w;
        logic [63:0]     sd;

        #1;
        chk_reset_outputs("reset_async");
        req_valid = '1;
        #1;
        chk("reset_noready", req_ready, '0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("reset_release");

        // directed cases
        run_op(0, 0, 1'b1, 0, 1'b1);
        chk("cos0_const", last_data, 64'h3FF0_0000_0000_0000);
        run_op(1, 210, 1'b0, 0, 1'b1);
        chk("sin210_sign", last_data[63], 1'b1);
        run_op(0, 90, 1'b1, 0, 1'b1);
        chk("cos90_zero", last_data, 64'd0);
        run_op(1, 270, 1'b1, 1, 1'b1);
        chk("cos270_zero", last_data, 64'd0);
        run_op(0, 180, 1'b0, 0, 1'b1);
        chk("sin180_zero", last_data, 64'd0);
        run_op(1, 359, 1'b0, 0, 1'b1);
        run_op(0, 400, 1'b1, 0, 1'b1);
        run_op(1, 511, 1'b0, 0, 1'b1);
        run_op(0, 360, 1'b0, 2, 1'b1);

        // randomized single-requester operations
        for (int n = 0; n < 30; n++) begin
            run_op(int'($urandom_range(0, NUM_REQ - 1)), int'($urandom_range(0, 511)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b1);
        end

        // all requesters valid continuously: round-robin and throughput
        c_grants = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_angle[i*9 +: 9] = 9'(45 + 10 * i);
            req_func[i] = 1'(i);
        end
        req_valid = '1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            chk("rr_onehot", ($countones(req_ready) <= 1), 1);
            if (|req_ready) begin
                w = rr_next;
                chk("rr_order", req_ready, onehot(w));
                exp_ids.push_back(w);
                rr_next = (w + 1) % NUM_REQ;
                c_grants++;
            end
            if (resp_valid) begin
                if (exp_ids.size() == 0) begin
                    chk("rr_resp_unexpected", resp_valid, 0);
                end else begin
                    w = exp_ids.pop_front();
                    chk("rr_resp_id", resp_id, w);
                    chk("rr_resp_data", resp_data,
                        exp_data(1'(w), (45 + 10 * w) / 90, 45 + 10 * w));
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_grant_count", c_grants, 8);
        chk("rr_all_answered", exp_ids.size(), 0);

        // stall in RESP, then reset mid-response
        run_op(0, 123, 1'b1, 10, 1'b0);
        sd = resp_data;
        chk("stall_data", sd, exp_data(1'b1, 1, 57));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("reset_mid");
        req_valid[1] = 1'b1;
        #1;
        chk("reset_mid_noready", req_ready, '0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        rr_next = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            chk("post_reset_noresp", {resp_valid, lut_en_sin, lut_en_cos}, 0);
        end

        // pointer back at requester 0 after reset
        req_angle = {9'(30), 9'(60)};
        req_func  = '0;
        req_valid = '1;
        #1;
        chk("post_reset_rr", req_ready, onehot(rr_next));
        req_valid = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
